emit2_cnt_dp: RTL and testbench
===============================

// Module: emit2_cnt_dp
// PURPOSE
//  Counter datapath for dispenser channel 2; the emit2 control FSM drives it.
//  Takes cnt2_ld/cnt2_clr/cnt2_ACK/count2 from the controller and returns count_ACK2/eq_0.
//  Latches the requested pour amount in units and counts it down, one unit per TICK_DIV clocks of count2.
//  Drives the channel-2 valve and reports the remaining amount and completion.
// PARAMETERS
//  CNT_W     8     width of amount/remaining counter (max 2^CNT_W-1 units)
//  TICK_DIV  1000  clocks of count2 per dispensed unit (>=1); prescaler width = $clog2(TICK_DIV), min 1
// PORTS
//  clk         in   1      system clock, rising edge
//  RESET       in   1      asynchronous reset, active-low
//  cnt2_ld     in   1      load request from emit2 controller
//  cnt2_clr    in   1      clear request from controller (asserted in controller IDLE)
//  cnt2_ACK    in   1      controller WAIT indicator; qualifies cnt2_ld (see load rule)
//  count2      in   1      controller COUNT state: run prescaler
//  amount2     in   CNT_W  requested units, sampled on load
//  count_ACK2  out  1      registered 1-cycle pulse: one unit dispensed
//  eq_0        out  1      remaining == 0 (combinational from counter register)
//  remain2     out  CNT_W  remaining units (counter register)
//  valve2      out  1      registered valve enable
//  done2       out  1      registered 1-cycle pulse when remaining goes 1 -> 0
// BEHAVIOUR
//  Reset (RESET=0, async): cnt=0, presc=0, count_ACK2=0, valve2=0, done2=0. eq_0 therefore reads 1.
//  Per-edge priority: cnt2_clr > load > tick > hold.
//  Clear: cnt=0, presc=0, count_ACK2=0, valve2=0, done2=0.
//  Load rule:
//   - load = cnt2_ld & ~cnt2_ACK (controller INIT): cnt<=amount2, presc<=0.
//   - cnt2_ld & cnt2_ACK (controller WAIT) holds cnt; it never reloads.
//  Prescaler:
//   - Counts while count2=1 and count_ACK2=0; forced to 0 whenever count2=0.
//  Tick: count2 & ~count_ACK2 & presc==TICK_DIV-1. On that edge:
//   - count_ACK2<=1, presc<=0.
//   - cnt<=cnt-1 if cnt!=0, else cnt stays 0 (saturate; ACK still issued so the FSM never hangs).
//   - done2<=1 iff cnt==1.
//  count_ACK2 and done2 are high for exactly one cycle and cleared on the next edge.
//   - During the ACK cycle the prescaler is held at 0, so no back-to-back re-tick while count2 is still high.
//  Latency:
//   - First ACK comes TICK_DIV cycles after count2 rises. TICK_DIV=1 gives ACK on the 1st count2 edge.
//   - eq_0 reflects the decremented value in the same cycle count_ACK2 is high, so the FSM sees it in WAIT.
//  valve2 <= count2 & (cnt!=0) & ~cnt2_clr. It drops 1 cycle after count2 falls or cnt reaches 0.
//  amount2==0 on load: eq_0=1 next cycle; no ticks or valve follow unless count2 is forced.
//  Reset mid-operation: all state cleared immediately, valve2 off asynchronously; the next operation needs a fresh load.
//  amount2 changes after load have no effect until the next load.
// STRUCTURE
//  Shared package emit_pkg:
//   - controller state encodings IDLE=2'b00, INIT=2'b01, WAIT=2'b10, COUNT=2'b11
//   - default CNT_W and TICK_DIV constants, shared by emit1/emit2 controller and datapath
//  Sub-module presc_tick #(TICK_DIV) (clk, RESET, run, hold, tick):
//   - reusable prescaler producing the tick strobe
//   - emit2_cnt_dp holds counter, ACK/done/valve registers and the priority logic
// TESTING (TICK_DIV=4, CNT_W=8 unless noted)
//  1 Reset: RESET=0 with random inputs -> all outputs 0 except eq_0=1; release -> outputs hold.
//  2 Full pour:
//    - stimulus: ld=1,ACK=0,amount2=3 for 1 cycle; then ld=1,ACK=1; then count2=1 until each ACK
//    - expect: count_ACK2 pulses 4 cycles after each count2 rise; remain2 3->2->1->0
//    - expect: done2 with the last ACK; eq_0=1; valve2 high only while counting and cnt!=0
//  3 WAIT hold: ld=1,ACK=1 with amount2=9 while remain2=2 -> remain2 stays 2.
//  4 Zero amount: load amount2=0 -> eq_0=1 next cycle; forced count2 -> ACK after 4 cycles, remain2 stays 0, no done2, valve2=0.
//  5 Clear/reset mid-count:
//    - clr at presc=2 -> remain2=0, no ACK issued
//    - repeat with RESET low between edges -> valve2 falls asynchronously
//  6 TICK_DIV=1, amount2=2, count2 held high -> ACKs exactly every other cycle (never consecutive), remain2 2->1->0.

Source files
------------

// File: rtl/emit_pkg.sv
// -----------------------------------------------------------------------------
// emit_pkg
// Shared definitions for the emit1/emit2 dispenser channels. Both the
// controllers and the counter datapaths import this package.
//   - emit_state_e : controller state encoding (IDLE/INIT/WAIT/COUNT)
//   - CNT_W_DEF    : default width of the amount/remaining counter
//   - TICK_DIV_DEF : default clocks of COUNT per dispensed unit
//   - presc_width(): width of a prescaler that counts 0..TICK_DIV-1 (min 1)
// -----------------------------------------------------------------------------
package emit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INIT  = 2'b01,
    WAIT  = 2'b10,
    COUNT = 2'b11
  } emit_state_e;

  localparam int CNT_W_DEF    = 8;
  localparam int TICK_DIV_DEF = 1000;

  // A divide-by-1 prescaler still needs one bit so the register is never zero-width.
  function automatic int presc_width(input int tick_div);
    if (tick_div > 1) begin
      return $clog2(tick_div);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/presc_tick.sv
// -----------------------------------------------------------------------------
// presc_tick
// Reusable prescaler. While 'run' is high and 'hold' is low it counts
// 0..TICK_DIV-1 and raises 'tick' combinationally in the terminal-count cycle.
// Dropping 'run' returns the count to 0; 'hold' parks it at 0.
// Ports:
//   clk   in  1  system clock, rising edge
//   RESET in  1  asynchronous reset, active-low
//   run   in  1  count enable (low forces the count to 0)
//   hold  in  1  freeze at 0 (used during the consumer's acknowledge cycle)
//   tick  out 1  terminal-count strobe
// -----------------------------------------------------------------------------
module presc_tick
  import emit_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic RESET,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int            PW   = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_last;

  assign w_last = (r_presc == LAST);
  assign tick   = run & ~hold & w_last;

  // Prescaler count: zero when idle, held or wrapping, otherwise increment.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_presc <= {PW{1'b0}};
    end else if (!run || hold || w_last) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

endmodule

// File: rtl/emit2_cnt_dp.sv
// -----------------------------------------------------------------------------
// emit2_cnt_dp
// Counter datapath for dispenser channel 2, steered by the emit2 controller.
// Latches the requested amount on load, counts it down one unit per TICK_DIV
// clocks of count2, drives the valve and reports remaining/completion.
// Ports:
//   clk        in  1      system clock, rising edge
//   RESET      in  1      asynchronous reset, active-low
//   cnt2_ld    in  1      load request (effective only when cnt2_ACK=0)
//   cnt2_clr   in  1      synchronous clear, highest priority
//   cnt2_ACK   in  1      controller WAIT indicator, blocks reload
//   count2     in  1      controller COUNT state, runs the prescaler
//   amount2    in  CNT_W  requested units, sampled on load
//   count_ACK2 out 1      registered 1-cycle pulse per dispensed unit
//   eq_0       out 1      remaining == 0
//   remain2    out CNT_W  remaining units
//   valve2     out 1      registered valve enable
//   done2      out 1      registered 1-cycle pulse when remaining goes 1 -> 0
// -----------------------------------------------------------------------------
module emit2_cnt_dp
  import emit_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             cnt2_ld,
  input  logic             cnt2_clr,
  input  logic             cnt2_ACK,
  input  logic             count2,
  input  logic [CNT_W-1:0] amount2,
  output logic             count_ACK2,
  output logic             eq_0,
  output logic [CNT_W-1:0] remain2,
  output logic             valve2,
  output logic             done2
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_done;
  logic             r_valve;

  logic             w_load;
  logic             w_run;
  logic             w_tick;
  logic             w_cnt_nz;
  logic [CNT_W-1:0] w_cnt_dec;

  // Load is only honoured in INIT; in WAIT the controller keeps cnt2_ld high
  // but the count must not be reloaded.
  assign w_load   = cnt2_ld & ~cnt2_ACK;
  // Clear and load both reset the prescaler, so they also stop it running.
  assign w_run    = count2 & ~cnt2_clr & ~w_load;
  assign w_cnt_nz = (r_cnt != {CNT_W{1'b0}});

  presc_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .RESET (RESET),
    .run   (w_run),
    .hold  (r_ack),
    .tick  (w_tick)
  );

  // Saturating decrement: a tick at zero still acknowledges so the FSM cannot hang.
  always_comb begin
    w_cnt_dec = r_cnt;
    if (w_cnt_nz) begin
      w_cnt_dec = r_cnt - CNT_W'(1);
    end else begin
      w_cnt_dec = r_cnt;
    end
  end

  // Counter, acknowledge and done registers with clear > load > tick > hold priority.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end else if (cnt2_clr) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= amount2;
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= w_cnt_dec;
      r_ack  <= 1'b1;
      r_done <= (r_cnt == CNT_W'(1));
    end else begin
      r_cnt  <= r_cnt;
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end
  end

  // Valve enable: open only while counting with units left and not clearing.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_valve <= 1'b0;
    end else begin
      r_valve <= count2 & w_cnt_nz & ~cnt2_clr;
    end
  end

  assign count_ACK2 = r_ack;
  assign done2      = r_done;
  assign valve2     = r_valve;
  assign remain2    = r_cnt;
  assign eq_0       = ~w_cnt_nz;

endmodule

// File: tb/tb_emit2_cnt_dp.sv
// -----------------------------------------------------------------------------
// tb_emit2_cnt_dp
// Directed bench for emit2_cnt_dp. Instance u_a uses TICK_DIV=4, instance u_b
// uses TICK_DIV=1. Expected acknowledge results are queued when count2 is
// driven and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_emit2_cnt_dp;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_ld, a_clr, a_ackin, a_cnt2;
  logic [7:0] a_amt;
  logic       a_ack, a_eq0, a_valve, a_done;
  logic [7:0] a_rem;

  logic       b_ld, b_clr, b_ackin, b_cnt2;
  logic [7:0] b_amt;
  logic       b_ack, b_eq0, b_valve, b_done;
  logic [7:0] b_rem;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] rem;
    logic       ack;
    logic       done;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  emit2_cnt_dp #(.CNT_W(8), .TICK_DIV(4)) u_a (
    .clk        (clk),
    .RESET      (rst_n),
    .cnt2_ld    (a_ld),
    .cnt2_clr   (a_clr),
    .cnt2_ACK   (a_ackin),
    .count2     (a_cnt2),
    .amount2    (a_amt),
    .count_ACK2 (a_ack),
    .eq_0       (a_eq0),
    .remain2    (a_rem),
    .valve2     (a_valve),
    .done2      (a_done)
  );

  emit2_cnt_dp #(.CNT_W(8), .TICK_DIV(1)) u_b (
    .clk        (clk),
    .RESET      (rst_n),
    .cnt2_ld    (b_ld),
    .cnt2_clr   (b_clr),
    .cnt2_ACK   (b_ackin),
    .count2     (b_cnt2),
    .amount2    (b_amt),
    .count_ACK2 (b_ack),
    .eq_0       (b_eq0),
    .remain2    (b_rem),
    .valve2     (b_valve),
    .done2      (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a_ack; n = cycles after count2 rose, 99 if it never came.
  task automatic wait_ack_a(output int n, output logic v_mid);
    n     = 99;
    v_mid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 2) v_mid = a_valve;
      if (a_ack === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int   n;
    logic v_mid;
    logic seen;
    exp_t e;

    // 1: reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_ld = 1'($urandom); a_clr = 1'($urandom); a_ackin = 1'($urandom);
      a_cnt2 = 1'($urandom); a_amt = 8'($urandom);
      b_ld = 1'($urandom); b_clr = 1'($urandom); b_ackin = 1'($urandom);
      b_cnt2 = 1'($urandom); b_amt = 8'($urandom);
      step();
    end
    chk("rst_ack",   32'(a_ack),   32'd0);
    chk("rst_eq0",   32'(a_eq0),   32'd1);
    chk("rst_rem",   32'(a_rem),   32'd0);
    chk("rst_valve", 32'(a_valve), 32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_b_eq0", 32'(b_eq0),   32'd1);
    a_ld = 1'b0; a_clr = 1'b0; a_ackin = 1'b0; a_cnt2 = 1'b0; a_amt = 8'd0;
    b_ld = 1'b0; b_clr = 1'b0; b_ackin = 1'b0; b_cnt2 = 1'b0; b_amt = 8'd0;
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_eq0",   32'(a_eq0),   32'd1);
    chk("post_rst_rem",   32'(a_rem),   32'd0);
    chk("post_rst_valve", 32'(a_valve), 32'd0);

    // 2 + 3: full pour of 3 units, with a WAIT reload attempt after the first ACK
    a_ld = 1'b1; a_ackin = 1'b0; a_amt = 8'd3;
    step();
    chk("load_rem", 32'(a_rem), 32'd3);
    chk("load_eq0", 32'(a_eq0), 32'd0);
    a_ackin = 1'b1;
    step();
    a_ld = 1'b0; a_ackin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sbq.push_back('{rem: 8'(2 - k), ack: 1'b1, done: (k == 2)});
      a_cnt2 = 1'b1;
      wait_ack_a(n, v_mid);
      e = sbq.pop_front();
      chk("pour_latency", 32'(n),       32'd4);
      chk("pour_rem",     32'(a_rem),   32'(e.rem));
      chk("pour_done",    32'(a_done),  32'(e.done));
      chk("pour_eq0",     32'(a_eq0),   32'(e.rem == 8'd0));
      chk("pour_valve",   32'(v_mid),   32'd1);
      a_cnt2 = 1'b0; a_ld = 1'b1; a_ackin = 1'b1;
      if (k == 0) a_amt = 8'd9;
      step();
      chk("pour_ack_pulse",  32'(a_ack),   32'd0);
      chk("pour_done_pulse", 32'(a_done),  32'd0);
      chk("pour_valve_off",  32'(a_valve), 32'd0);
      if (k == 0) chk("wait_hold_rem", 32'(a_rem), 32'd2);
      a_ld = 1'b0; a_ackin = 1'b0;
    end

    // 4: zero amount, forced count2
    a_ld = 1'b1; a_ackin = 1'b0; a_amt = 8'd0;
    step();
    chk("zero_eq0", 32'(a_eq0), 32'd1);
    chk("zero_rem", 32'(a_rem), 32'd0);
    a_ld = 1'b0;
    sbq.push_back('{rem: 8'd0, ack: 1'b1, done: 1'b0});
    a_cnt2 = 1'b1;
    wait_ack_a(n, v_mid);
    e = sbq.pop_front();
    chk("zero_latency", 32'(n),       32'd4);
    chk("zero_rem_ack", 32'(a_rem),   32'(e.rem));
    chk("zero_done",    32'(a_done),  32'(e.done));
    chk("zero_valve",   32'(v_mid),   32'd0);
    a_cnt2 = 1'b0;
    step();

    // 5a: clear when prescaler has reached 2
    a_ld = 1'b1; a_amt = 8'd5;
    step();
    a_ld = 1'b0; a_cnt2 = 1'b1;
    step();
    step();
    chk("clr_pre_valve", 32'(a_valve), 32'd1);
    a_clr = 1'b1;
    step();
    chk("clr_rem",   32'(a_rem),   32'd0);
    chk("clr_valve", 32'(a_valve), 32'd0);
    chk("clr_ack",   32'(a_ack),   32'd0);
    a_clr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (a_ack === 1'b1) seen = 1'b1;
    end
    a_cnt2 = 1'b0;
    chk("clr_no_ack", 32'(seen), 32'd0);
    step();

    // 5b: asynchronous reset mid-count
    a_ld = 1'b1; a_amt = 8'd5;
    step();
    a_ld = 1'b0; a_cnt2 = 1'b1;
    step();
    step();
    chk("arst_pre_valve", 32'(a_valve), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valve", 32'(a_valve), 32'd0);
    chk("arst_rem",   32'(a_rem),   32'd0);
    chk("arst_eq0",   32'(a_eq0),   32'd1);
    a_cnt2 = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("arst_after_rem", 32'(a_rem), 32'd0);

    // 6: TICK_DIV=1, amount 2, count2 held high
    b_ld = 1'b1; b_ackin = 1'b0; b_amt = 8'd2;
    step();
    chk("td1_load_rem", 32'(b_rem), 32'd2);
    b_ld = 1'b0;
    sbq.push_back('{rem: 8'd1, ack: 1'b1, done: 1'b0});
    sbq.push_back('{rem: 8'd1, ack: 1'b0, done: 1'b0});
    sbq.push_back('{rem: 8'd0, ack: 1'b1, done: 1'b1});
    sbq.push_back('{rem: 8'd0, ack: 1'b0, done: 1'b0});
    b_cnt2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      e = sbq.pop_front();
      chk("td1_ack",  32'(b_ack),  32'(e.ack));
      chk("td1_rem",  32'(b_rem),  32'(e.rem));
      chk("td1_done", 32'(b_done), 32'(e.done));
    end
    b_cnt2 = 1'b0;
    step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
